// File: rtl/tff_seq_pkg.sv
// rtl/tff_seq_pkg.sv - state encodings and width limit for the T-cell counter sequencer
package tff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with synchronous active-high reset
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/tff_count_seq.sv
// rtl/tff_count_seq.sv - start/done sequencer driving a bank of T cells as a programmable counter
module tff_count_seq
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("tff_count_seq: WIDTH below minimum");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] tgt_r;
  logic             dir_r;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_cnt;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] init_v;
  logic [WIDTH-1:0] end_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign init_v = dir_r ? '0 : tgt_r;
  assign end_v  = dir_r ? tgt_r : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tgt_r <= '0;
      dir_r <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        tgt_r <= limit;
        dir_r <= up_dn;
      end
    end
  end

  // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic all1;
    logic all0;
    t_cnt = '0;
    all1  = 1'b1;
    all0  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_cnt[i] = dir_r ? all1 : all0;
      all1     = all1 & q[i];
      all0     = all0 & qbar[i];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (abort)                state_next = IDLE;
        else if (init_v == end_v) state_next = DONE;
        else                      state_next = RUN;
      end
      RUN: begin
        if (abort)                        state_next = IDLE;
        else if (!hold && ((q ^ t_cnt) == end_v)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    t = '0;
    case (state)
      LOAD:    if (!abort) t = q ^ init_v;
      RUN:     if (!abort && !hold) t = t_cnt;
      default: t = '0;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tff_count_seq.sv
// tb/tb_tff_count_seq.sv - randomized and directed checks of tff_count_seq against a behavioural model
module tb_tff_count_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         up_dn = 1'b0;
  logic [W-1:0] limit = '0;
  logic         hold = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase 0 idle, 1 load, 2 run, 3 done
  int           m_phase = 0;
  logic [W-1:0] m_q   = '0;
  logic [W-1:0] m_tgt = '0;
  logic         m_up  = 1'b0;

  tff_count_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .up_dn (up_dn),
    .limit (limit),
    .hold  (hold),
    .abort (abort),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] goal;
    goal = m_up ? m_tgt : '0;
    if (rst) begin
      m_phase = 0; m_q = '0; m_tgt = '0; m_up = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin m_tgt = limit; m_up = up_dn; m_phase = 1; end
        1: begin
          if (abort) m_phase = 0;
          else begin
            m_q = m_up ? '0 : m_tgt;
            m_phase = (m_q == goal) ? 3 : 2;
          end
        end
        2: begin
          if (abort) m_phase = 0;
          else if (!hold) begin
            m_q = m_up ? m_q + 1'b1 : m_q - 1'b1;
            if (m_q == goal) m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic ud, input logic [W-1:0] lim,
                      input logic h, input logic a);
    rst = r; start = s; up_dn = ud; limit = lim; hold = h; abort = a;
    @(posedge clk);
    model_step();
    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 3));
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Starts a run at E0 and reports the edge index after which done is first seen.
  task automatic timed_run(input logic ud, input logic [W-1:0] lim, input int hold_from,
                           input int hold_len, input int exp_edge, input string tag);
    int edge_n;
    int pulses;
    logic h;
    edge_n = 0;
    pulses = 0;
    tick(1'b0, 1'b1, ud, lim, 1'b0, 1'b0);
    while (!done && edge_n < 400) begin
      edge_n++;
      h = (edge_n >= hold_from) && (edge_n < hold_from + hold_len);
      tick(1'b0, h, ~ud, ~lim, h, 1'b0);
    end
    chk({tag, "_done_edge"}, 32'(edge_n), 32'(exp_edge));
    chk({tag, "_final_q"}, 32'(q), ud ? 32'(lim) : 32'd0);
    while (done && pulses < 4) begin
      pulses++;
      idle_tick();
    end
    chk({tag, "_done_width"}, 32'(pulses), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    idle_tick();

    timed_run(1'b1, 8'd5, 0, 0, 6, "up5");
    timed_run(1'b0, 8'hA3, 0, 0, 164, "dnA3");
    timed_run(1'b1, 8'd0, 0, 0, 1, "up0");
    timed_run(1'b0, 8'd0, 0, 0, 1, "dn0");
    timed_run(1'b1, 8'd4, 3, 3, 8, "hold4");

    // abort at q=3 in an up run to 9
    tick(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
    repeat (4) idle_tick();
    chk("abort_pre_q", 32'(q), 32'd3);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("abort_q", 32'(q), 32'd3);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) begin
      idle_tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
    idle_tick();
    chk("reload_q", 32'(q), 32'd0);
    while (busy) idle_tick();

    // rst at q=6 during a down run from 10, with start asserted alongside
    tick(1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0);
    repeat (5) idle_tick();
    chk("rst_pre_q", 32'(q), 32'd6);
    tick(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
    idle_tick();
    chk("rst_start_ignored", 32'(busy), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] lim;
      lim = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 20));
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           lim, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_count_seq.md
# tff_count_seq

Controller that turns a bank of WIDTH T flip-flop cells into a start/done-handshaked programmable counter. It sequences the cells' toggle inputs: a one-cycle load of the start value, then a count up to or down from a programmed limit, with hold and abort. It sits beside the D/T flip-flop primitives and reuses the T flip-flop as its only storage for the count value.

## Interface
- WIDTH, 8, counter width (number of T cells), min 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- up_dn  input  1  1 = count 0→limit, 0 = count limit→0; latched with start
- limit  input  WIDTH  programmed limit; latched with start
- hold  input  1  pause counting in RUN (no toggles)
- abort  input  1  cancel run in LOAD/RUN
- q  output  WIDTH  current count (T cell outputs)
- busy  output  1  state != IDLE
- done  output  1  one-cycle completion pulse (state == DONE)

## Operation
- Reset: state IDLE, all cells q=0, busy=0, done=0, latched limit/direction=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: T=0. start=1 → latch limit→tgt_r, up_dn→dir_r; go LOAD. start is ignored in every other state.
- LOAD: init = 0 if dir_r=1 else tgt_r; end = tgt_r if dir_r=1 else 0. T = q ^ init, so q equals init after one edge. Next state: DONE if init == end, else RUN.
- RUN, hold=0: up: T[0]=1, T[i]=&q[i-1:0]; down: T[0]=1, T[i]=&(~q[i-1:0]). If the next q equals end → DONE, else stay. hold=1: T=0, stay.
- DONE: T=0, done=1; next state IDLE. q keeps its final value until the next LOAD.
- abort=1 in LOAD or RUN → IDLE next edge, T=0, no done, q frozen. abort takes priority over hold and over completion. Ignored in IDLE/DONE.
- Arithmetic is modulo 2^WIDTH. Termination by equality means wrap never occurs in a legal run.
- limit=0: up run goes LOAD→DONE. Down run loads 0 and goes LOAD→DONE.
- rst during any state: IDLE and q=0 at that edge, overriding abort/start.

## Timing
- start high at edge E0 (IDLE): busy=1 after E0 (LOAD). q=init after E1.
- Run of length L=limit: q steps once per un-held edge. q reaches end after edge E(1+L+H), where H = number of held RUN cycles. done=1 for exactly the following cycle. busy falls one edge later.
- L=0: done high between E1 and E2.
- Earliest new start is sampled at the edge after done deasserts (state IDLE).
- q, busy and done are all registered outputs. No combinational path from inputs to outputs.

## Structure
- Package tff_seq_pkg: state encodings IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3, and the WIDTH minimum check constant.
- Sub-module tff_cell: one T flip-flop with synchronous active-high reset. Ports clk, rst, t, q, qbar. Instantiated WIDTH times by generate.
- The controller holds only the state, tgt_r and dir_r registers plus the combinational T-vector/next-q logic. The count lives solely in the tff_cells.

## Test plan
- WIDTH=8, up_dn=1, limit=5, start at E0 → q=0 after E1, q=1..5 after E2..E6, done high E6–E7 only, busy low after E7.
- up_dn=0, limit=8'hA3 → q=A3 after E1, decrements to 0 after E164, single done pulse.
- limit=0 in both directions → LOAD→DONE. done high E1–E2. q=0.
- hold high for 3 cycles mid up-run with limit=4 → q frozen for 3 cycles, done delayed by exactly 3 cycles. start pulses during the run are ignored.
- abort at q=3 in up-run with limit=9 → IDLE next edge, q stays 3, done never asserts. A new start then reloads q=0.
- rst asserted at q=6 during a down run → q=0, busy=0, done=0 after that edge. A start during rst is ignored.
